// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op-codes, controller states and default width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_DIVU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_DONE
    } state_e;

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per enabled cycle.
// Outputs present the values after the current step, so the caller can register them on the final step.
module muldiv_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] quotient,
    output logic             finished
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;
    logic             div_mode;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             freeze;

    // Multiply keeps the partial product in hi and the shrinking multiplier in lo;
    // divide keeps the partial remainder in hi and the growing quotient in lo.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_reg};
        div_diff  = div_shift[WIDTH-1:0] - b_reg;
        rem_next  = div_ge ? div_diff : div_shift[WIDTH-1:0];
        quo_next  = {lo_reg[WIDTH-2:0], div_ge};
        hi_next   = div_mode ? rem_next : mul_sum[WIDTH:1];
        lo_next   = div_mode ? quo_next : {mul_sum[0], lo_reg[WIDTH-1:1]};
        freeze    = div_mode && (b_reg == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            b_reg    <= '0;
            div_mode <= 1'b0;
            count    <= '0;
        end else if (load) begin
            hi_reg   <= '0;
            lo_reg   <= a;
            b_reg    <= b;
            div_mode <= is_div;
            count    <= '0;
        end else if (step) begin
            count <= count + CW'(1);
            if (!freeze) begin
                hi_reg <= hi_next;
                lo_reg <= lo_next;
            end
        end
    end

    assign prod_hi  = mul_sum[WIDTH:1];
    assign prod_lo  = {mul_sum[0], lo_reg[WIDTH-1:1]};
    assign quotient = quo_next;
    assign finished = step && (count == CW'(WIDTH - 1));

endmodule

// File: rtl/multicycle_alu.sv
// ALU controller: single-cycle ops complete in one cycle, MUL/DIVU iterate WIDTH cycles in muldiv_iter.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             ovfl,
    output logic             carry,
    output logic             divz
);

    state_e           state, state_next;
    logic [2:0]       op_reg;
    logic             div_zero;
    logic             accept;
    logic             finished;
    logic [WIDTH-1:0] prod_hi, prod_lo, quotient;

    logic [WIDTH:0]   add_ext, sub_ext;
    logic [WIDTH-1:0] alu_r;
    logic             alu_ovfl, alu_carry;

    assign accept  = start && ready;
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_r     = '0;
        alu_ovfl  = 1'b0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD: begin
                alu_r     = add_ext[WIDTH-1:0];
                alu_carry = add_ext[WIDTH];
                alu_ovfl  = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extension bit is the borrow, so carry means "no borrow".
                alu_r     = sub_ext[WIDTH-1:0];
                alu_carry = ~sub_ext[WIDTH];
                alu_ovfl  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_r = a & b;
            OP_OR:   alu_r = a | b;
            OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  alu_r = a << b[SHW-1:0];
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = is_iterative(op) ? ST_ITER : ST_DONE;
            ST_ITER: if (finished) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Results change only on completion, so they hold through IDLE until the next op finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_reg   <= OP_ADD;
            div_zero <= 1'b0;
            r        <= '0;
            ovfl     <= 1'b0;
            carry    <= 1'b0;
            divz     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_reg   <= op;
                div_zero <= (op == OP_DIVU) && (b == '0);
                if (!is_iterative(op)) begin
                    r     <= alu_r;
                    ovfl  <= alu_ovfl;
                    carry <= alu_carry;
                    divz  <= 1'b0;
                end
            end else if ((state == ST_ITER) && finished) begin
                carry <= 1'b0;
                if (op_reg == OP_MUL) begin
                    r    <= prod_lo;
                    ovfl <= |prod_hi;
                    divz <= 1'b0;
                end else begin
                    r    <= div_zero ? '1 : quotient;
                    ovfl <= 1'b0;
                    divz <= div_zero;
                end
            end
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && is_iterative(op)),
        .step     (state == ST_ITER),
        .is_div   (op == OP_DIVU),
        .a        (a),
        .b        (b),
        .prod_hi  (prod_hi),
        .prod_lo  (prod_lo),
        .quotient (quotient),
        .finished (finished)
    );

    assign ready = (state == ST_IDLE);
    assign done  = (state == ST_DONE);
    assign zero  = (r == '0);

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed table, randomized ops against an arithmetic model,
// and hand-written control sequences for held start and mid-operation reset.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int WIDTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        ready, done, zero, ovfl, carry, divz;
    logic [15:0] r;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        z;
        logic        o;
        logic        c;
        logic        d;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(WIDTH), .SHW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .r     (r),
        .zero  (zero),
        .ovfl  (ovfl),
        .carry (carry),
        .divz  (divz)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Arithmetic reference: wide signed/unsigned integers, no bit-level tricks.
    function automatic void model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] er, output logic eo, output logic ec, output logic ed);
        longint ux, uy, sx, sy, t;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        er = 16'h0;
        eo = 1'b0;
        ec = 1'b0;
        ed = 1'b0;
        t  = 0;
        case (o)
            OP_ADD: begin
                t  = ux + uy;
                er = t[15:0];
                ec = (t > 65535);
                eo = ((sx + sy) > 32767) || ((sx + sy) < -32768);
            end
            OP_SUB: begin
                t  = ux - uy;
                er = t[15:0];
                ec = (ux >= uy);
                eo = ((sx - sy) > 32767) || ((sx - sy) < -32768);
            end
            OP_AND: er = x & y;
            OP_OR:  er = x | y;
            OP_SLT: er = (sx < sy) ? 16'd1 : 16'd0;
            OP_SLL: begin
                t  = ux << (uy % 16);
                er = t[15:0];
            end
            OP_MUL: begin
                t  = ux * uy;
                er = t[15:0];
                eo = ((t >> 16) != 0);
            end
            default: begin
                if (uy == 0) begin
                    er = 16'hFFFF;
                    ed = 1'b1;
                end else begin
                    t  = ux / uy;
                    er = t[15:0];
                end
            end
        endcase
    endfunction

    // Called at a negative edge with the DUT idle; returns the cycle in which done was seen, or -1.
    task automatic applyStimulus(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, output int lat);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic runVector(input string name, input vec_t v);
        int lat;
        @(negedge clk);
        checkOutput({name, ".ready"}, ready, 1);
        applyStimulus(v.op, v.a, v.b, lat);
        checkOutput({name, ".latency"}, lat, v.lat);
        checkOutput({name, ".r"}, r, v.r);
        checkOutput({name, ".zero"}, zero, v.z);
        checkOutput({name, ".ovfl"}, ovfl, v.o);
        checkOutput({name, ".carry"}, carry, v.c);
        checkOutput({name, ".divz"}, divz, v.d);
        @(posedge clk);
        #1;
        checkOutput({name, ".done_pulse"}, done, 0);
        checkOutput({name, ".ready_after"}, ready, 1);
        checkOutput({name, ".r_hold"}, r, v.r);
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, ".r"}, r, 0);
        checkOutput({name, ".zero"}, zero, 1);
        checkOutput({name, ".ovfl"}, ovfl, 0);
        checkOutput({name, ".carry"}, carry, 0);
        checkOutput({name, ".divz"}, divz, 0);
        checkOutput({name, ".done"}, done, 0);
        checkOutput({name, ".ready"}, ready, 1);
    endtask

    initial begin
        vec_t v;
        int   pulses, done_cyc, ready_errs;
        logic [15:0] er;
        logic eo, ec, ed;

        vecs[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[1]  = '{OP_SUB,  16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[4]  = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[5]  = '{OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{OP_OR,   16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{OP_SLT,  16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{OP_SLT,  16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{OP_SLL,  16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{OP_MUL,  16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 17};
        vecs[11] = '{OP_MUL,  16'h00FF, 16'h0003, 16'h02FD, 1'b0, 1'b0, 1'b0, 1'b0, 17};
        vecs[12] = '{OP_DIVU, 16'd100,  16'd7,    16'h000E, 1'b0, 1'b0, 1'b0, 1'b0, 17};
        vecs[13] = '{OP_DIVU, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 17};
        vecs[14] = '{OP_DIVU, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 17};
        vecs[15] = '{OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 17};

        reset = 1'b1;
        start = 1'b0;
        op    = OP_ADD;
        a     = 16'h0;
        b     = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("por");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) runVector($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 40; i++) begin
            v.op = 3'($urandom_range(0, 7));
            v.a  = 16'($urandom);
            v.b  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            model(v.op, v.a, v.b, v.r, v.o, v.c, v.d);
            v.z   = (v.r == 16'h0);
            v.lat = (v.op == OP_MUL || v.op == OP_DIVU) ? 17 : 1;
            runVector($sformatf("rnd%0d", i), v);
        end

        // start held high through a MUL, with operands scrambled after accept
        @(negedge clk);
        start = 1'b1;
        op    = OP_MUL;
        a     = 16'h1234;
        b     = 16'h0056;
        model(OP_MUL, 16'h1234, 16'h0056, er, eo, ec, ed);
        @(posedge clk);
        #1;
        pulses     = 0;
        done_cyc   = -1;
        ready_errs = 0;
        for (int c = 1; c <= 18; c++) begin
            if (done === 1'b1) begin
                pulses++;
                done_cyc = c;
                checkOutput("held.r", r, er);
                checkOutput("held.ovfl", ovfl, eo);
            end
            if (ready !== (c == 18)) ready_errs++;
            @(negedge clk);
            a = 16'($urandom);
            b = 16'($urandom);
            if (c == 18) start = 1'b0;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("held.pulses", pulses, 1);
        checkOutput("held.done_cycle", done_cyc, 17);
        checkOutput("held.ready_errors", ready_errs, 0);

        // reset asserted in cycle 5 of a MUL
        @(negedge clk);
        start = 1'b1;
        op    = OP_MUL;
        a     = 16'h00FF;
        b     = 16'h0003;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        checkResetState("midreset");
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checkOutput("midreset.pulses", pulses, 0);
        checkOutput("midreset.ready", ready, 1);

        v = '{OP_ADD, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        runVector("post_reset_add", v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
